// File: rtl/pc_branch_unit.sv
// Fetch program counter with branch redirect, stall hold and wrong-path flush sequencing.
// The 6-bit shifted branch offset is sign-extended and added to the branch's PC+2.
module pc_branch_unit #(
    parameter int unsigned     PC_W         = 8,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int unsigned     FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] br_base,
    input  logic [5:0]      br_offset_sh,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus2,
    output logic            if_valid,
    output logic            flush,
    output logic [PC_W-1:0] target
);

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } state_e;

    localparam logic [PC_W-1:0] Two      = PC_W'(2);
    localparam logic [PC_W-1:0] EvenMask = ~PC_W'(1);
    localparam logic [1:0]      CntInit  = 2'(FLUSH_CYCLES - 1);

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [PC_W-1:0] pc_d, target_d;
    logic            flush_d, if_valid_d;
    logic [PC_W-1:0] off_ext, tgt;

    assign off_ext  = {{(PC_W-6){br_offset_sh[5]}}, br_offset_sh};
    // Halfword-aligned target: bit0 dropped whatever the offset says.
    assign tgt      = (br_base + off_ext) & EvenMask;
    assign pc_plus2 = pc + Two;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc;
        target_d   = target;
        flush_d    = flush;
        if_valid_d = if_valid;
        unique case (state_q)
            StBoot: begin
                state_d    = StRun;
                if_valid_d = 1'b1;
            end
            StRun: begin
                if (branch_taken) begin
                    pc_d     = tgt;
                    target_d = tgt;
                    flush_d  = 1'b1;
                    cnt_d    = CntInit;
                    state_d  = StFlush;
                end else if (!stall) begin
                    pc_d = pc_plus2;
                end
            end
            StFlush: begin
                // branch_taken here comes from a squashed instruction.
                if (!stall) begin
                    pc_d = pc_plus2;
                    if (cnt_q == 2'd0) begin
                        flush_d = 1'b0;
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
            default: begin
                state_d    = StRun;
                flush_d    = 1'b0;
                if_valid_d = 1'b1;
                cnt_d      = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StBoot;
            cnt_q    <= 2'd0;
            pc       <= RESET_PC;
            target   <= '0;
            flush    <= 1'b0;
            if_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc       <= pc_d;
            target   <= target_d;
            flush    <= flush_d;
            if_valid <= if_valid_d;
        end
    end

endmodule
